// File: rtl/alu_mdu.sv
// EX-stage integer unit: single-cycle base ops plus iterative RV32M multiply/divide.
// Sits behind valid/ready handshakes on both the request and the result side.
module alu_mdu #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            InValid,
  output logic            InReady,
  input  logic [XLEN-1:0] Operand1,
  input  logic [XLEN-1:0] Operand2,
  input  logic [4:0]      AluOp,
  input  logic            Flush,
  output logic            OutValid,
  input  logic            OutReady,
  output logic [XLEN-1:0] AluOut,
  output logic            IllegalOp
);
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q;
  logic              in_ready_q, out_valid_q, illegal_q;
  logic [XLEN-1:0]   alu_out_q;
  logic [1:0]        op_q;
  logic              sign1_q, sign2_q;
  logic [CW-1:0]     count_q;
  logic [2*XLEN-1:0] acc_q, mcand_q;
  logic [XLEN-1:0]   mplier_q;

  logic            is_mul, is_div, op1_signed, op2_signed, sign1_d, sign2_d;
  logic [XLEN-1:0] mag1_d, mag2_d, div_special;
  logic            div_zero, div_ovf, base_ill;
  logic [XLEN-1:0] base_res;
  logic [SHW-1:0]  shamt;

  assign is_mul     = (AluOp[4:2] == 3'b100);
  assign is_div     = (AluOp[4:2] == 3'b101);
  // MUL/MULH: s*s, MULHSU: s*u, MULHU: u*u; DIV/REM signed, DIVU/REMU unsigned
  assign op1_signed = is_mul ? (AluOp[1:0] != 2'b11) : (is_div && !AluOp[0]);
  assign op2_signed = is_mul ? !AluOp[1] : (is_div && !AluOp[0]);
  assign sign1_d    = op1_signed & Operand1[XLEN-1];
  assign sign2_d    = op2_signed & Operand2[XLEN-1];
  assign mag1_d     = sign1_d ? -Operand1 : Operand1;
  assign mag2_d     = sign2_d ? -Operand2 : Operand2;
  assign div_zero   = (Operand2 == '0);
  assign div_ovf    = !AluOp[0] && (Operand1 == MOST_NEG) && (Operand2 == '1);
  assign div_special = div_zero ? (AluOp[1] ? Operand1 : '1)
                                : (AluOp[1] ? '0 : Operand1);
  assign shamt      = Operand2[SHW-1:0];

  always_comb begin
    base_res = '0;
    base_ill = 1'b0;
    case (AluOp)
      5'd0:    base_res = Operand1 << shamt;
      5'd1:    base_res = Operand1 >> shamt;
      5'd2:    base_res = $signed(Operand1) >>> shamt;
      5'd3:    base_res = Operand1 + Operand2;
      5'd4:    base_res = Operand1 - Operand2;
      5'd5:    base_res = Operand1 ^ Operand2;
      5'd6:    base_res = Operand1 | Operand2;
      5'd7:    base_res = Operand1 & Operand2;
      5'd8:    base_res = {{(XLEN-1){1'b0}}, ($signed(Operand1) < $signed(Operand2))};
      5'd9:    base_res = {{(XLEN-1){1'b0}}, (Operand1 < Operand2)};
      5'd10:   base_res = Operand2;
      default: base_ill = 1'b1;
    endcase
  end

  // acc_q holds the product for MUL; for DIV it is {remainder, dividend/quotient}
  logic [XLEN:0]     div_shift, div_sub;
  logic              div_ge;
  logic [2*XLEN-1:0] acc_step, prod_fix;
  logic [XLEN-1:0]   quo, rem, mul_res, div_res, fin_res;

  assign div_shift = acc_q[2*XLEN-1:XLEN-1];
  assign div_sub   = div_shift - {1'b0, mcand_q[XLEN-1:0]};
  assign div_ge    = ~div_sub[XLEN];
  assign acc_step  = (state_q == S_MUL)
                   ? acc_q + (mplier_q[0] ? mcand_q : '0)
                   : {(div_ge ? div_sub[XLEN-1:0] : div_shift[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};

  // Final iteration folds in the sign fixup so the result lands XLEN cycles after accept
  assign prod_fix = (sign1_q ^ sign2_q) ? -acc_step : acc_step;
  assign mul_res  = (op_q == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
  assign quo      = acc_step[XLEN-1:0];
  assign rem      = acc_step[2*XLEN-1:XLEN];
  assign div_res  = op_q[1] ? (sign1_q ? -rem : rem) : ((sign1_q ^ sign2_q) ? -quo : quo);
  assign fin_res  = (state_q == S_MUL) ? mul_res : div_res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
      alu_out_q   <= '0;
      op_q        <= '0;
      sign1_q     <= 1'b0;
      sign2_q     <= 1'b0;
      count_q     <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
    end else if (Flush) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          in_ready_q <= 1'b1;
          if (InValid && in_ready_q) begin
            in_ready_q <= 1'b0;
            op_q       <= AluOp[1:0];
            sign1_q    <= sign1_d;
            sign2_q    <= sign2_d;
            count_q    <= '0;
            if (is_mul) begin
              acc_q    <= '0;
              mcand_q  <= {{XLEN{1'b0}}, mag1_d};
              mplier_q <= mag2_d;
              state_q  <= S_MUL;
            end else if (is_div && (div_zero || div_ovf)) begin
              alu_out_q   <= div_special;
              illegal_q   <= 1'b0;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end else if (is_div) begin
              acc_q   <= {{XLEN{1'b0}}, mag1_d};
              mcand_q <= {{XLEN{1'b0}}, mag2_d};
              state_q <= S_DIV;
            end else begin
              alu_out_q   <= base_ill ? '0 : base_res;
              illegal_q   <= base_ill;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end
          end
        end
        S_MUL, S_DIV: begin
          acc_q   <= acc_step;
          count_q <= count_q + CW'(1);
          if (state_q == S_MUL) begin
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
          end
          if (count_q == CW'(XLEN-1)) begin
            alu_out_q   <= fin_res;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (OutReady) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign InReady   = in_ready_q;
  assign OutValid  = out_valid_q;
  assign AluOut    = alu_out_q;
  assign IllegalOp = illegal_q;
endmodule

// File: tb/tb_alu_mdu.sv
// Directed bench for alu_mdu at XLEN=32: results, latencies, handshake, flush and reset.
module tb_alu_mdu;
  logic        clk, rst_n, InValid, InReady, Flush, OutValid, OutReady, IllegalOp;
  logic [31:0] Operand1, Operand2, AluOut;
  logic [4:0]  AluOp;
  int tests = 0;
  int fails = 0;

  alu_mdu #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .InValid(InValid), .InReady(InReady),
    .Operand1(Operand1), .Operand2(Operand2), .AluOp(AluOp), .Flush(Flush),
    .OutValid(OutValid), .OutReady(OutReady), .AluOut(AluOut), .IllegalOp(IllegalOp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request and retire its result; latency counts edges from accept to first edge seeing OutValid.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic ill, output int lat,
                        output logic ready_seen);
    int n;
    n = 0;
    ready_seen = 1'b0;
    while (!InReady && n < 50) begin @(posedge clk); #1; n++; end
    AluOp = op; Operand1 = a; Operand2 = b; InValid = 1'b1;
    @(posedge clk); #1;
    InValid = 1'b0;
    lat = 1;
    while (!OutValid && lat < 100) begin
      if (InReady) ready_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    res = AluOut;
    ill = IllegalOp;
    OutReady = 1'b1;
    @(posedge clk); #1;
    OutReady = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    tests++;
    if (OutValid !== 1'b0 || AluOut !== 32'h0 || IllegalOp !== 1'b0 || InReady !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: got ov=%b out=%h ill=%b rdy=%b, want 0 0 0 0", OutValid, AluOut, IllegalOp, InReady);
    end else $display("reset_state ok");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (InReady !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: got %b want 1", InReady);
    end else $display("reset_ready ok");
  endtask

  task automatic test_base();
    logic [4:0]  op [10];
    logic [31:0] a [10], b [10], e [10];
    logic [31:0] res; logic ill, rs; int lat;
    op[0]=5'd3;  a[0]=32'h7FFFFFFF; b[0]=32'h1;        e[0]=32'h80000000;
    op[1]=5'd2;  a[1]=32'h80000000; b[1]=32'h24;       e[1]=32'hF8000000;
    op[2]=5'd8;  a[2]=32'hFFFFFFFF; b[2]=32'h1;        e[2]=32'h1;
    op[3]=5'd9;  a[3]=32'hFFFFFFFF; b[3]=32'h1;        e[3]=32'h0;
    op[4]=5'd4;  a[4]=32'd5;        b[4]=32'd7;        e[4]=32'hFFFFFFFE;
    op[5]=5'd5;  a[5]=32'hF0F0F0F0; b[5]=32'hFF00FF00; e[5]=32'h0FF00FF0;
    op[6]=5'd0;  a[6]=32'h1;        b[6]=32'h21;       e[6]=32'h2;
    op[7]=5'd1;  a[7]=32'h80000000; b[7]=32'h1F;       e[7]=32'h1;
    op[8]=5'd10; a[8]=32'hDEADBEEF; b[8]=32'h12345000; e[8]=32'h12345000;
    op[9]=5'd7;  a[9]=32'hFF00FF00; b[9]=32'h0FF00FF0; e[9]=32'h0F000F00;
    for (int i = 0; i < 10; i++) begin
      run_op(op[i], a[i], b[i], res, ill, lat, rs);
      tests++;
      if (res !== e[i] || ill !== 1'b0 || lat !== 1) begin
        fails++;
        $display("FAIL base_op%0d: got out=%h ill=%b lat=%0d, want out=%h ill=0 lat=1", op[i], res, ill, lat, e[i]);
      end else $display("base op%0d %h,%h -> %h lat %0d ok", op[i], a[i], b[i], res, lat);
    end
  endtask

  task automatic test_mul();
    logic [4:0]  op [5];
    logic [31:0] a [5], b [5], e [5];
    logic [31:0] res; logic ill, rs; int lat;
    op[0]=5'd16; a[0]=32'hFFFFFFFF; b[0]=32'hFFFFFFFF; e[0]=32'h00000001;
    op[1]=5'd17; a[1]=32'hFFFFFFFF; b[1]=32'hFFFFFFFF; e[1]=32'h00000000;
    op[2]=5'd19; a[2]=32'hFFFFFFFF; b[2]=32'hFFFFFFFF; e[2]=32'hFFFFFFFE;
    op[3]=5'd18; a[3]=32'hFFFFFFFF; b[3]=32'hFFFFFFFF; e[3]=32'hFFFFFFFF;
    op[4]=5'd17; a[4]=32'h80000000; b[4]=32'h80000000; e[4]=32'h40000000;
    for (int i = 0; i < 5; i++) begin
      run_op(op[i], a[i], b[i], res, ill, lat, rs);
      tests++;
      if (res !== e[i] || ill !== 1'b0 || lat !== 33 || rs !== 1'b0) begin
        fails++;
        $display("FAIL mul_op%0d: got out=%h lat=%0d busy_ready=%b, want out=%h lat=33 busy_ready=0", op[i], res, lat, rs, e[i]);
      end else $display("mul op%0d %h,%h -> %h lat %0d ok", op[i], a[i], b[i], res, lat);
    end
  endtask

  task automatic test_div();
    logic [4:0]  op [4];
    logic [31:0] a [4], b [4], e [4];
    logic [31:0] res; logic ill, rs; int lat;
    op[0]=5'd20; a[0]=32'hFFFFFFF9; b[0]=32'd2;   e[0]=32'hFFFFFFFD;
    op[1]=5'd22; a[1]=32'hFFFFFFF9; b[1]=32'd2;   e[1]=32'hFFFFFFFF;
    op[2]=5'd21; a[2]=32'd100;      b[2]=32'd7;   e[2]=32'd14;
    op[3]=5'd23; a[3]=32'd100;      b[3]=32'd7;   e[3]=32'd2;
    for (int i = 0; i < 4; i++) begin
      run_op(op[i], a[i], b[i], res, ill, lat, rs);
      tests++;
      if (res !== e[i] || ill !== 1'b0 || lat !== 33 || rs !== 1'b0) begin
        fails++;
        $display("FAIL div_op%0d: got out=%h lat=%0d busy_ready=%b, want out=%h lat=33 busy_ready=0", op[i], res, lat, rs, e[i]);
      end else $display("div op%0d %h,%h -> %h lat %0d ok", op[i], a[i], b[i], res, lat);
    end
  endtask

  task automatic test_div_special();
    logic [4:0]  op [5];
    logic [31:0] a [5], b [5], e [5];
    logic [31:0] res; logic ill, rs; int lat;
    op[0]=5'd20; a[0]=32'd5;        b[0]=32'd0;        e[0]=32'hFFFFFFFF;
    op[1]=5'd22; a[1]=32'd5;        b[1]=32'd0;        e[1]=32'd5;
    op[2]=5'd20; a[2]=32'h80000000; b[2]=32'hFFFFFFFF; e[2]=32'h80000000;
    op[3]=5'd22; a[3]=32'h80000000; b[3]=32'hFFFFFFFF; e[3]=32'h0;
    op[4]=5'd21; a[4]=32'h80000000; b[4]=32'h0;        e[4]=32'hFFFFFFFF;
    for (int i = 0; i < 5; i++) begin
      run_op(op[i], a[i], b[i], res, ill, lat, rs);
      tests++;
      if (res !== e[i] || ill !== 1'b0 || lat !== 1) begin
        fails++;
        $display("FAIL divspec_op%0d: got out=%h lat=%0d, want out=%h lat=1", op[i], res, lat, e[i]);
      end else $display("divspec op%0d %h,%h -> %h lat %0d ok", op[i], a[i], b[i], res, lat);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] res; logic ill, rs; int lat;
    run_op(5'd31, 32'h12345678, 32'h9ABCDEF0, res, ill, lat, rs);
    tests++;
    if (res !== 32'h0 || ill !== 1'b1 || lat !== 1) begin
      fails++;
      $display("FAIL illegal_31: got out=%h ill=%b lat=%0d, want 0 1 1", res, ill, lat);
    end else $display("illegal op31 -> out %h ill %b ok", res, ill);
    run_op(5'd12, 32'h1, 32'h1, res, ill, lat, rs);
    tests++;
    if (res !== 32'h0 || ill !== 1'b1 || lat !== 1) begin
      fails++;
      $display("FAIL illegal_12: got out=%h ill=%b lat=%0d, want 0 1 1", res, ill, lat);
    end else $display("illegal op12 -> out %h ill %b ok", res, ill);
  endtask

  task automatic test_backpressure();
    AluOp = 5'd3; Operand1 = 32'd3; Operand2 = 32'd4; InValid = 1'b1;
    @(posedge clk); #1;
    InValid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (OutValid !== 1'b1 || AluOut !== 32'd7 || InReady !== 1'b0) begin
        fails++;
        $display("FAIL hold_c%0d: got ov=%b out=%h rdy=%b, want 1 00000007 0", i, OutValid, AluOut, InReady);
      end else $display("hold cycle %0d out %h ok", i, AluOut);
      @(posedge clk); #1;
    end
    OutReady = 1'b1;
    @(posedge clk); #1;
    OutReady = 1'b0;
    tests++;
    if (OutValid !== 1'b0 || InReady !== 1'b1) begin
      fails++;
      $display("FAIL retire: got ov=%b rdy=%b, want 0 1", OutValid, InReady);
    end else $display("retire ok");
  endtask

  task automatic test_flush();
    logic seen;
    AluOp = 5'd20; Operand1 = 32'd1000; Operand2 = 32'd3; InValid = 1'b1;
    @(posedge clk); #1;
    InValid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    Flush = 1'b1;
    @(posedge clk); #1;
    Flush = 1'b0;
    tests++;
    if (OutValid !== 1'b0 || InReady !== 1'b1) begin
      fails++;
      $display("FAIL flush_div: got ov=%b rdy=%b, want 0 1", OutValid, InReady);
    end else $display("flush mid-div ok");
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (OutValid) seen = 1'b1;
      @(posedge clk); #1;
    end
    tests++;
    if (seen !== 1'b0) begin
      fails++;
      $display("FAIL flush_noresult: got OutValid seen=%b want 0", seen);
    end else $display("flush no result ok");
    AluOp = 5'd3; Operand1 = 32'd1; Operand2 = 32'd1; InValid = 1'b1; Flush = 1'b1;
    @(posedge clk); #1;
    InValid = 1'b0; Flush = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (OutValid !== 1'b0 || InReady !== 1'b1) begin
      fails++;
      $display("FAIL flush_priority: got ov=%b rdy=%b, want 0 1", OutValid, InReady);
    end else $display("flush beats accept ok");
  endtask

  task automatic test_reset_mid();
    logic [31:0] res; logic ill, rs; int lat;
    run_op(5'd3, 32'd1, 32'd2, res, ill, lat, rs);
    AluOp = 5'd16; Operand1 = 32'd7; Operand2 = 32'd9; InValid = 1'b1;
    @(posedge clk); #1;
    InValid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (OutValid !== 1'b0 || AluOut !== 32'h0 || InReady !== 1'b0 || IllegalOp !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: got ov=%b out=%h rdy=%b ill=%b, want 0 0 0 0", OutValid, AluOut, InReady, IllegalOp);
    end else $display("async reset mid-mul ok");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(5'd16, 32'd7, 32'd9, res, ill, lat, rs);
    tests++;
    if (res !== 32'd63 || lat !== 33) begin
      fails++;
      $display("FAIL mul_after_reset: got out=%h lat=%0d, want 0000003f 33", res, lat);
    end else $display("mul after reset -> %h ok", res);
  endtask

  initial begin
    rst_n = 1'b0; InValid = 1'b0; Flush = 1'b0; OutReady = 1'b0;
    AluOp = 5'd0; Operand1 = 32'h0; Operand2 = 32'h0;
    test_reset();
    test_base();
    test_mul();
    test_div();
    test_div_special();
    test_illegal();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
- Parametrised successor to the single-cycle execute ALU.
- Executes the base integer ops plus RV32M-style multiply/divide/remainder over an XLEN-bit datapath.
- Base ops complete in one registered cycle; MUL/DIV ops run iteratively, one bit per cycle.
- Sits in the EX stage behind a valid/ready handshake, so the pipeline stalls on a busy unit instead of assuming fixed latency.

Parameters:
- XLEN, 32, operand/result width; power of two, >= 8.
- SHW, $clog2(XLEN), shift-amount width, taken from Operand2[SHW-1:0].

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- InValid  in  1  request valid.
- InReady  out  1  unit can accept a request.
- Operand1  in  XLEN  first operand (rs1).
- Operand2  in  XLEN  second operand (rs2 or immediate).
- AluOp  in  5  operation code.
- Flush  in  1  synchronous abort of any in-flight op.
- OutValid  out  1  result valid.
- OutReady  in  1  consumer accepts result.
- AluOut  out  XLEN  result.
- IllegalOp  out  1  qualifies AluOut when OutValid; op code was unassigned.

Behaviour:
- Op codes, base group:
  - 0 SLL, 1 SRL, 2 SRA (arithmetic), 3 ADD, 4 SUB, 5 XOR, 6 OR, 7 AND.
  - 8 SLT (signed), 9 SLTU, 10 LUI (AluOut = Operand2).
- Op codes, M group:
  - 16 MUL (low XLEN), 17 MULH (s×s high), 18 MULHSU (s×u high), 19 MULHU (u×u high).
  - 20 DIV, 21 DIVU, 22 REM, 23 REMU.
- Unassigned codes: AluOut=0 and IllegalOp=1, with base-group latency.
- Reset (async, rst_n low): state=IDLE; OutValid=0; AluOut=0; IllegalOp=0; InReady=0 while rst_n low, 1 in IDLE after release; all iteration registers 0.
- Handshake:
  - Transfer occurs on any edge where valid&&ready.
  - InReady=1 only in IDLE.
  - Once asserted, OutValid, AluOut and IllegalOp hold stable until OutValid&&OutReady.
- States: IDLE, MUL, DIV, DONE.
  - IDLE, accept of a base/illegal op: compute combinationally, register into AluOut, go to DONE. OutValid rises 1 cycle after accept.
  - IDLE, accept of a MUL-group op: latch operand magnitudes and sign flags, count=0, go to MUL.
  - IDLE, accept of a DIV-group op: same latching, count=0, go to DIV.
  - MUL: shift-add, one multiplier bit per cycle into a 2*XLEN accumulator. After XLEN iterations, apply sign fixup (negate if result sign is negative), select low or high half, go to DONE. OutValid rises XLEN+1 cycles after accept (33 for XLEN=32).
  - DIV: restoring division on magnitudes, one quotient bit per cycle. After XLEN iterations, apply sign fixup (quotient sign = sign1^sign2; remainder sign = sign of dividend), go to DONE. Latency XLEN+1.
  - DONE: on OutReady go to IDLE; next accept no earlier than the following cycle.
- Division special cases are detected at accept and bypass iteration, with latency 1:
  - Divide by zero: quotient = all-ones, remainder = Operand1.
  - DIV/REM with Operand1 = most-negative and Operand2 = -1: quotient = Operand1, remainder = 0.
- MULHSU treats only Operand1 as signed.
- Shifts use Operand2[SHW-1:0] only; the upper bits are ignored.
- Flush=1 at any edge forces state=IDLE and OutValid=0 with no result produced. Flush has priority over a simultaneous accept: no request is taken that cycle.
- Reset asserted mid-operation: immediate return to reset values; partial result discarded.
- InValid while busy: ignored. The producer must hold the request until InReady.

Test Plan:
- Base ops, XLEN=32:
  - ADD 0x7FFFFFFF+1 -> 0x80000000, OutValid 1 cycle after accept.
  - SRA 0x80000000 by 0x24 -> shift 4 -> 0xF8000000.
  - SLT -1,1 -> 1; SLTU -1,1 -> 0.
- Multiply: MUL 0xFFFFFFFF×0xFFFFFFFF -> 0x00000001; MULH -> 0x00000000; MULHU -> 0xFFFFFFFE; MULHSU -> 0xFFFFFFFF. Each OutValid exactly 33 cycles after accept; InReady=0 throughout.
- Divide: DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2. Latency 33.
- Special cases:
  - DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5.
  - DIV 0x80000000/-1 -> 0x80000000; REM -> 0.
  - All with latency 1.
- Backpressure/abort:
  - OutReady=0 for 5 cycles after result -> AluOut stable, InReady=0; first edge with OutReady=1 retires it.
  - Flush at iteration 10 of DIV -> OutValid never rises, InReady=1 next cycle.
- Reset: rst_n pulled low mid-MUL, asynchronous to clk -> OutValid=0 and AluOut=0 immediately. Illegal op 31 -> AluOut=0, IllegalOp=1.
